pipe_hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the in-order RV32I pipeline. It generalises the fixed EX/MEM/WB load-use detector and forwarding unit into one block. It tracks every in-flight register writer in a shift-register scoreboard of `NSTAGE` entries, with a configurable load latency. It sits beside the ID stage, drives PC, IF/ID and ID/EX control, and hands registered forwarding selects to the EX operand muxes.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/sb_match.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds the scoreboard entry layout, the scoreboard update actions and reset values.
package pipe_pkg;

   localparam int unsigned RAW_MAX = 8;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   // Register addresses are zero-extended to RAW_MAX bits inside an entry
   typedef struct packed {
      logic               valid;
      logic [RAW_MAX-1:0] rd;
      logic               is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,
      ACT_SQUASH  = 2'd1,
      ACT_ADVANCE = 2'd2
   } sb_action_e;

   localparam sb_entry_t SB_ENTRY_RST = '0;
   localparam int unsigned FWD_SEL_RST = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard/forwarding bus: ID-side inputs plus pipeline enables and EX selects.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned RAW    = 5
);
   localparam int unsigned SEL_W = $clog2(NSTAGE);

   logic             id_valid;
   logic [RAW-1:0]   id_rs1;
   logic [RAW-1:0]   id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [RAW-1:0]   id_rd;
   logic             id_reg_write;
   logic             id_is_load;
   logic             ex_redirect;
   logic             ext_stall;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [SEL_W-1:0] ex_fwd_rs1_sel;
   logic [SEL_W-1:0] ex_fwd_rs2_sel;
   logic             id_rs1_wb_bypass;
   logic             id_rs2_wb_bypass;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_is_load, ex_redirect, ext_stall,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
             ex_fwd_rs1_sel, ex_fwd_rs2_sel, id_rs1_wb_bypass, id_rs2_wb_bypass
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_is_load, ex_redirect, ext_stall,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
             ex_fwd_rs1_sel, ex_fwd_rs2_sel, id_rs1_wb_bypass, id_rs2_wb_bypass
   );

endinterface

// File: rtl/sb_match.sv
// Youngest-match priority encoder over the writer scoreboard for one source operand.
// Returns hit, the matching entry index and whether its data is forwardable.
module sb_match
   import pipe_pkg::*;
#(
   parameter int unsigned  NSTAGE   = 3,
   parameter int unsigned  LOAD_LAT = 1,
   localparam int unsigned K_W      = $clog2(NSTAGE)
) (
   input  sb_entry_t [NSTAGE-1:0] entries,
   input  logic [RAW_MAX-1:0]     src,
   input  logic                   used,
   output logic                   hit,
   output logic [K_W-1:0]         k,
   output logic                   ready
);

   // Lowest index is the youngest writer, so the first hit wins
   always_comb begin
      hit   = 1'b0;
      k     = '0;
      ready = 1'b0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
         if (!hit && entries[i].valid && (entries[i].rd == src) &&
             (src != '0) && used) begin
            hit   = 1'b1;
            k     = K_W'(i);
            ready = !entries[i].is_load || (i >= LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based hazard detection and EX forwarding-select generation beside ID.
// Optional macro HAZARD_WB_BYPASS_EN: a WB-stage match bypasses into ID instead of stalling.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned NSTAGE   = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned RAW      = 5
) (
   input logic               clk,
   input logic               reset_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned      SEL_W = $clog2(NSTAGE);
   localparam logic [SEL_W-1:0] WB_K  = SEL_W'(NSTAGE - 1);
`ifdef HAZARD_WB_BYPASS_EN
   localparam logic WB_STALL = 1'b0;
`else
   localparam logic WB_STALL = 1'b1;
`endif

   sb_entry_t [NSTAGE-1:0] sb;
   sb_entry_t              new_entry;
   sb_action_e             action;
   logic [SEL_W-1:0]       sel1_q, sel2_q, sel1_c, sel2_c, k1, k2;
   logic                   hit1, hit2, rdy1, rdy2, wb1, wb2, stall1, stall2, hazard_c;

   sb_match #(.NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_match_rs1 (
      .entries (sb),
      .src     (RAW_MAX'(bus.id_rs1[RAW-1:0])),
      .used    (bus.id_rs1_used),
      .hit     (hit1),
      .k       (k1),
      .ready   (rdy1)
   );

   sb_match #(.NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) u_match_rs2 (
      .entries (sb),
      .src     (RAW_MAX'(bus.id_rs2[RAW-1:0])),
      .used    (bus.id_rs2_used),
      .hit     (hit2),
      .k       (k2),
      .ready   (rdy2)
   );

   // A WB-stage match is either bypassed into ID or stalled until the writer retires
   assign wb1      = hit1 && (k1 == WB_K);
   assign wb2      = hit2 && (k2 == WB_K);
   assign stall1   = hit1 && (wb1 ? WB_STALL : !rdy1);
   assign stall2   = hit2 && (wb2 ? WB_STALL : !rdy2);
   assign hazard_c = stall1 || stall2;
   assign sel1_c   = (hit1 && !wb1 && rdy1) ? SEL_W'(k1 + SEL_W'(1)) : '0;
   assign sel2_c   = (hit2 && !wb2 && rdy2) ? SEL_W'(k2 + SEL_W'(1)) : '0;

`ifdef HAZARD_WB_BYPASS_EN
   assign bus.id_rs1_wb_bypass = wb1;
   assign bus.id_rs2_wb_bypass = wb2;
`else
   assign bus.id_rs1_wb_bypass = 1'b0;
   assign bus.id_rs2_wb_bypass = 1'b0;
`endif

   always_comb begin
      new_entry.valid   = bus.id_valid && bus.id_reg_write && (bus.id_rd != '0);
      new_entry.rd      = RAW_MAX'(bus.id_rd[RAW-1:0]);
      new_entry.is_load = bus.id_is_load;
   end

   // Priority: memory freeze, then redirect, then hazard stall, then advance
   always_comb begin
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      action           = ACT_ADVANCE;
      if (bus.ext_stall) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         action          = ACT_HOLD;
      end else if (bus.ex_redirect) begin
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
         action           = ACT_SQUASH;
      end else if (hazard_c) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.id_ex_bubble = 1'b1;
         action           = ACT_SQUASH;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb     <= {NSTAGE{SB_ENTRY_RST}};
         sel1_q <= SEL_W'(FWD_SEL_RST);
         sel2_q <= SEL_W'(FWD_SEL_RST);
      end else begin
         case (action)
            ACT_SQUASH: begin
               sb     <= {sb[NSTAGE-2:0], SB_ENTRY_RST};
               sel1_q <= '0;
               sel2_q <= '0;
            end
            ACT_ADVANCE: begin
               sb     <= {sb[NSTAGE-2:0], new_entry};
               sel1_q <= sel1_c;
               sel2_q <= sel2_c;
            end
            default: ;
         endcase
      end
   end

   assign bus.ex_fwd_rs1_sel = sel1_q;
   assign bus.ex_fwd_rs2_sel = sel2_q;

endmodule
